aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequencing FSM for the AES-128 encryption core: accepts one block per valid/ready handshake and steps the datapath through the initial AddRoundKey, rounds 1..NR-1 (SubBytes, ShiftRows, MixColumns, AddRoundKey) and the final round (no MixColumns).
- Generates the round counter and Rcon for the on-the-fly key schedule.
- Sits between the host/SPI block and the combinational round datapath (add_round_key, shift_rows, sub_bytes, mix_columns, key_expand).
- Holds no state/key data; control only.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported; Rcon sequence is valid for NR<=10.
- RND_W, 4, round counter width; must satisfy 2**RND_W > NR.

Ports:
- clk  input  1  single clock, all flops rising edge.
- nreset  input  1  asynchronous, active-low reset.
- in_valid  input  1  plaintext/key present on the datapath inputs.
- in_ready  output  1  controller can accept a block.
- out_valid  output  1  ciphertext in datapath state register is final.
- out_ready  input  1  consumer takes ciphertext.
- init_ld  output  1  datapath loads state<=pt^key and rkey<=key this edge.
- st_en  output  1  datapath state register and round-key register update this edge.
- mix_en  output  1  MixColumns in path (0 = bypass).
- sbox_en  output  1  synchronous S-box lookup strobe (see Optional Feature; else tied to st_en).
- round  output  RND_W  current round number 0..NR.
- rcon  output  8  Rcon byte for the key expansion performed this cycle.
- busy  output  1  block in flight (ROUND/SUB states).

Behaviour:
- Reset: state IDLE, round=0, rcon=8'h01; all strobes 0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
- IDLE: in_ready=1. Accept = in_valid & in_ready; on accept: init_ld=1 (combinational), round<=1, rcon<=8'h01, next ROUND.
- ROUND: st_en=1, busy=1, mix_en=(round!=NR). On each edge: if round==NR, next DONE; else round<=round+1, rcon<=xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
- Rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- DONE: out_valid=1 and held until out_ready. On out_valid & out_ready: next IDLE, round<=0, rcon<=8'h01.
- Back-to-back: in_ready = IDLE | (DONE & out_ready). If a new accept coincides with the DONE handshake, go straight to ROUND with round=1 and assert init_ld in that cycle.
- in_valid while busy or in DONE without out_ready: ignored; in_ready=0; no state change.
- Latency: accept edge at cycle 0; out_valid first high at cycle NR+1 (11). Throughput: one block per NR+1 cycles when out_ready is held high.
- out_valid, init_ld, st_en and mix_en are never asserted together with reset low.
- nreset asserted mid-operation: immediate return to reset values; the in-flight block is discarded with no out_valid.
- st_en and init_ld are mutually exclusive.

Optional Feature:
- Macro: AES_SYNC_SBOX_EN.
- Defined: each round is preceded by a SUB state with sbox_en=1, st_en=0, busy=1, so the synchronous (block-RAM) S-box registers its output. SUB always goes to ROUND; ROUND goes to SUB for the next round, or to DONE after round NR. round and rcon advance only on ROUND edges. Latency is 2*NR+1 (21) cycles.
- Undefined: no SUB state; sbox_en=st_en; latency is NR+1.

Decomposition:
- aes_pkg holds: ctrl_state_t enum (IDLE, SUB, ROUND, DONE); localparams NR_128=10, RCON_INIT=8'h01, RCON_POLY=8'h1B; state_t typedef logic [7:0] [3:0][3:0] shared with the datapath; function xtime(byte).
- One natural sub-module: aes_rcon_gen (register with load-to-01 / advance enable), reused by the decrypt-side controller later.

Test Plan:
- Reset then single block: in_valid=1 at cycle 0 -> init_ld=1 at cycle 0; st_en high cycles 1..10; mix_en low only at round=10; out_valid at cycle 11.
- Rcon check: log rcon on each st_en cycle -> 01,02,04,08,10,20,40,80,1B,36 in order.
- Integration with datapath, FIPS-197 App. B (key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734) -> ciphertext 3925841d02dc09fbdc118597196a0b32 when out_valid is high.
- Backpressure and back-to-back: out_ready=0 for 5 cycles after done -> out_valid held, in_ready=0, in_valid ignored; then out_ready=1 with in_valid=1 -> same-cycle accept, init_ld=1, round=1 next.
- nreset pulsed low at round=5 -> outputs immediately at reset values; no out_valid; next block completes normally in 11 cycles.
- AES_SYNC_SBOX_EN build: single block -> sbox_en/st_en alternate, out_valid at cycle 21, same ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the encryption control path and datapath.
// Holds the controller state encoding, round/Rcon constants, the 128-bit
// state container type and the GF(2^8) xtime helper.
package aes_pkg;

  // Controller states; SUB is only reachable when AES_SYNC_SBOX_EN is defined
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUB   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  localparam int         NR_128    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // 16-byte AES state shared with the round datapath
  typedef logic [7:0][3:0][3:0] state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Rcon byte generator for the on-the-fly key schedule.
// load returns the byte to 01 (start of a block); adv steps it by xtime.
// load wins over adv. Shared with the decrypt-side controller.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] rcon
);

  logic [7:0] rcon_reg;

  // Rcon register: reset/load to 01, otherwise advance by xtime on request
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rcon_reg <= RCON_INIT;
    end else if (load) begin
      rcon_reg <= RCON_INIT;
    end else if (adv) begin
      rcon_reg <= xtime(rcon_reg);
    end
  end

  assign rcon = rcon_reg;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencing FSM for the AES-128 encryption core.
// Accepts one block per in_valid/in_ready handshake, pulses init_ld for the
// initial AddRoundKey, then runs NR round-update cycles (MixColumns bypassed
// in the last one) and holds out_valid until the consumer takes the result.
// Optional build macro AES_SYNC_SBOX_EN: inserts a SUB cycle before every
// round so a registered (block-RAM) S-box can produce its output; round and
// rcon still advance only on ROUND cycles.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = NR_128,  // only 10 is supported; Rcon is valid up to 10
  parameter int RND_W = 4        // 2**RND_W must exceed NR
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             init_ld,
  output logic             st_en,
  output logic             mix_en,
  output logic             sbox_en,
  output logic [RND_W-1:0] round,
  output logic [7:0]       rcon,
  output logic             busy
);

`ifdef AES_SYNC_SBOX_EN
  // Every round starts with an S-box lookup cycle
  localparam ctrl_state_t ROUND_ENTRY = SUB;
`else
  localparam ctrl_state_t ROUND_ENTRY = ROUND;
`endif

  ctrl_state_t      state_reg;
  ctrl_state_t      state_next;
  logic [RND_W-1:0] round_reg;
  logic             last_round;
  logic             accept;
  logic             drain;
  logic             round_adv;

  assign last_round = (round_reg == RND_W'(NR));
  // A new block is taken from IDLE, or from DONE in the same cycle the result leaves
  assign accept     = in_valid & in_ready;
  assign drain      = (state_reg == DONE) & out_ready;
  assign round_adv  = (state_reg == ROUND) & ~last_round;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = ROUND_ENTRY;
      SUB:     state_next = ROUND;
      ROUND:   state_next = last_round ? DONE : ROUND_ENTRY;
      DONE:    if (out_ready) state_next = in_valid ? ROUND_ENTRY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; init_ld is gated by nreset so no strobe escapes during reset
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    init_ld   = 1'b0;
    st_en     = 1'b0;
    mix_en    = 1'b0;
    sbox_en   = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        init_ld  = in_valid & nreset;
      end
      SUB: begin
        busy = 1'b1;
`ifdef AES_SYNC_SBOX_EN
        sbox_en = 1'b1;
`endif
      end
      ROUND: begin
        busy   = 1'b1;
        st_en  = 1'b1;
        mix_en = ~last_round;
`ifndef AES_SYNC_SBOX_EN
        // Combinational S-box: lookup strobe follows the state update
        sbox_en = 1'b1;
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        init_ld   = out_ready & in_valid & nreset;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Round counter: 1 on accept, +1 per non-final ROUND cycle, 0 when the result leaves
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      round_reg <= '0;
    end else if (accept) begin
      round_reg <= RND_W'(1);
    end else if (round_adv) begin
      round_reg <= round_reg + RND_W'(1);
    end else if (drain) begin
      round_reg <= '0;
    end
  end

  assign round = round_reg;

  // Rcon restarts at 01 for every new block and whenever the controller goes idle
  aes_rcon_gen u_rcon (
    .clk    (clk),
    .nreset (nreset),
    .load   (accept | drain),
    .adv    (round_adv),
    .rcon   (rcon)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl (default build, combinational S-box).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int NR    = 10;
  localparam int RND_W = 4;

  logic             clk = 1'b0;
  logic             nreset = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, init_ld, st_en, mix_en, sbox_en, busy;
  logic [RND_W-1:0] round;
  logic [7:0]       rcon;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR), .RND_W(RND_W)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .init_ld   (init_ld),
    .st_en     (st_en),
    .mix_en    (mix_en),
    .sbox_en   (sbox_en),
    .round     (round),
    .rcon      (rcon),
    .busy      (busy)
  );

  typedef struct packed {
    logic             in_ready;
    logic             out_valid;
    logic             init_ld;
    logic             st_en;
    logic             mix_en;
    logic             sbox_en;
    logic             busy;
    logic [RND_W-1:0] round;
    logic [7:0]       rcon;
  } obs_t;

  typedef struct {
    logic in_valid;
    logic out_ready;
    obs_t exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t       vecs[NVEC];
  logic [7:0] rcon_tab[10];
  int         checks = 0;
  int         errors = 0;

  // Expected observation; sbox_en mirrors st_en in this build
  function automatic obs_t mk(input logic ir, input logic ov, input logic il, input logic st,
                              input logic mx, input logic bz, input int rnd, input logic [7:0] rc);
    obs_t o;
    o = {ir, ov, il, st, mx, st, bz, RND_W'(rnd), rc};
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o = {in_ready, out_valid, init_ld, st_en, mix_en, sbox_en, busy, round, rcon};
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("rdy=%b ov=%b ild=%b st=%b mix=%b sbx=%b busy=%b round=%0d rcon=%h",
                     o.in_ready, o.out_valid, o.init_ld, o.st_en, o.mix_en, o.sbox_en,
                     o.busy, o.round, o.rcon);
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = cur();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, fmt(act), fmt(exp));
    end else begin
      $display("ok   %s: %s", name, fmt(act));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Count cycles until out_valid; cycle counter starts at 'start', bounded at 40
  task automatic wait_out_valid(input string name, input int start, input int exp_cycle);
    int  cyc;
    bit  seen;
    cyc  = start;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) cyc = -1;
    check_int(name, cyc, exp_cycle);
  endtask

  // Accept a block at cycle 0 and check init_ld and output latency
  task automatic run_block(input string name);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    check_obs({name, "_accept"}, mk(1, 0, 1, 0, 0, 0, 0, 8'h01));
    wait_out_valid({name, "_latency"}, 0, NR + 1);
  endtask

  // Take the result and check the controller returns to IDLE
  task automatic drain(input string name);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check_obs({name, "_idle"}, mk(1, 0, 0, 0, 0, 0, 0, 8'h01));
  endtask

  initial begin
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // Single block with backpressure, ignored in_valid in DONE, then drain
    vecs[0] = '{1'b1, 1'b0, mk(1, 0, 1, 0, 0, 0, 0, 8'h01)};
    for (int k = 1; k <= NR; k++) begin
      vecs[k] = '{1'b0, 1'b0, mk(0, 0, 0, 1, (k != NR), 1, k, rcon_tab[k-1])};
    end
    vecs[11] = '{1'b0, 1'b0, mk(0, 1, 0, 0, 0, 0, 10, 8'h36)};
    vecs[12] = '{1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0, 10, 8'h36)};
    vecs[13] = '{1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0, 10, 8'h36)};
    vecs[14] = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 8'h01)};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_obs("reset", mk(1, 0, 0, 0, 0, 0, 0, 8'h01));
    @(negedge clk);
    nreset = 1'b1;

    // Table-driven single block
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      in_valid  = vecs[i].in_valid;
      out_ready = vecs[i].out_ready;
      #1;
      check_obs($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Backpressure for 5 cycles, then back-to-back accept on the DONE handshake
    run_block("b2b_first");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      check_obs($sformatf("hold%0d", k), mk(0, 1, 0, 0, 0, 0, 10, 8'h36));
    end
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_obs("b2b_handshake", mk(1, 1, 1, 0, 0, 0, 10, 8'h36));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_obs("b2b_round1", mk(0, 0, 0, 1, 1, 1, 1, 8'h01));
    wait_out_valid("b2b_second_latency", 1, NR + 1);
    drain("b2b");

    // Asynchronous reset at round 5 discards the block
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
    end
    check_obs("pre_reset_round5", mk(0, 0, 0, 1, 1, 1, 5, 8'h10));
    #2;
    nreset = 1'b0;
    #1;
    check_obs("async_reset", mk(1, 0, 0, 0, 0, 0, 0, 8'h01));
    @(negedge clk);
    #1;
    check_obs("reset_held", mk(1, 0, 0, 0, 0, 0, 0, 8'h01));
    nreset = 1'b1;
    run_block("post_reset");
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
